fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the pipelined MIPS core: owns the fetch PC register and drives a variable-latency instruction memory with a req/ack handshake.
- Holds one fetched instruction for the ID stage.
- Applies the next-PC redirect resolved in ID with delayed-branch semantics: the delay slot always issues, then the target.
- Sits between the instruction memory, the IF/ID boundary, the hazard unit (stall) and the ID-stage next-PC logic.

---
 rtl/fetch_ctrl_pkg.sv | 15 +
 rtl/fetch_ctrl.sv | 118 +++++++++++
 tb/tb_fetch_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: widths, reset PC and state encoding.
package fetch_ctrl_pkg;

  localparam int unsigned PcW    = 32;
  localparam int unsigned InstrW = 32;

  localparam logic [PcW-1:0] DefaultResetPc = 32'h0000_3000;

  typedef enum logic [1:0] {
    StBoot,
    StReq,
    StFull
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch PC sequencer: drives a req/ack instruction memory, buffers one instruction for ID and
// applies ID-stage redirects with delayed-branch semantics (delay slot first, then target).
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [PcW-1:0] RESET_PC = DefaultResetPc
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_id,
  input  logic              redir_valid,
  input  logic [PcW-1:0]    redir_target,
  output logic              im_req,
  output logic [PcW-1:0]    im_addr,
  input  logic              im_ack,
  input  logic [InstrW-1:0] im_rdata,
  output logic              if_valid,
  output logic [InstrW-1:0] if_instr,
  output logic [PcW-1:0]    if_pc
);

  fetch_state_e      state_q, state_d;
  logic [PcW-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PcW-1:0]    redir_pc_q, redir_pc_d;
  logic              redir_pend_q, redir_pend_d;
  logic [InstrW-1:0] if_instr_q, if_instr_d;
  logic [PcW-1:0]    if_pc_q, if_pc_d;

  logic redir;
  logic ack;

  // A redirect only counts when ID is actually advancing.
  assign redir = redir_valid & ~stall_id;

  always_comb begin
    im_req = 1'b0;
    unique case (state_q)
      StReq:   im_req = 1'b1;
      StFull:  im_req = ~stall_id & ~redir_valid;
      default: im_req = 1'b0;
    endcase
  end

  assign ack = im_req & im_ack;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    redir_pc_d   = redir_pc_q;
    redir_pend_d = redir_pend_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;

    // Any accepted response refills the buffer, whichever state issued the request.
    if (ack) begin
      if_instr_d = im_rdata;
      if_pc_d    = fetch_pc_q;
    end

    unique case (state_q)
      StBoot: state_d = StReq;
      StReq: begin
        if (ack) begin
          state_d      = StFull;
          redir_pend_d = 1'b0;
          if (redir) begin
            fetch_pc_d = redir_target;
          end else if (redir_pend_q) begin
            fetch_pc_d = redir_pc_q;
          end else begin
            fetch_pc_d = fetch_pc_q + PcW'(4);
          end
        end else if (redir) begin
          // Delay slot still in flight: remember the target until it lands.
          redir_pc_d   = redir_target;
          redir_pend_d = 1'b1;
        end
      end
      StFull: begin
        if (redir) begin
          fetch_pc_d = redir_target;
          state_d    = StReq;
        end else if (!stall_id) begin
          if (ack) begin
            fetch_pc_d = fetch_pc_q + PcW'(4);
          end else begin
            state_d = StReq;
          end
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StBoot;
      fetch_pc_q   <= RESET_PC;
      redir_pc_q   <= '0;
      redir_pend_q <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      redir_pc_q   <= redir_pc_d;
      redir_pend_q <= redir_pend_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
    end
  end

  assign im_addr  = fetch_pc_q;
  assign if_valid = (state_q == StFull);
  assign if_instr = if_instr_q;
  assign if_pc    = if_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a latency-programmable instruction memory model.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_id, redir_valid, im_req, im_ack, if_valid;
  logic [31:0] redir_target, im_addr, im_rdata, if_instr, if_pc;

  int   lat;
  logic force_ack;
  int   wait_cnt;
  int   n3010 = 0;
  int   n0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  fetch_ctrl u_dut (
    .clk         (clk),
    .reset       (reset),
    .stall_id    (stall_id),
    .redir_valid (redir_valid),
    .redir_target(redir_target),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .im_ack      (im_ack),
    .im_rdata    (im_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc)
  );

  // Memory acks on the lat-th cycle of a held request; data tags the address.
  assign im_ack   = (im_req && (wait_cnt >= lat - 1)) || force_ack;
  assign im_rdata = im_addr ^ 32'hA5A5_0000;

  always @(posedge clk or negedge reset) begin
    if (!reset) wait_cnt <= 0;
    else if (!im_req || im_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  always @(posedge clk) begin
    if (im_req && im_addr == 32'h0000_3010) n3010 <= n3010 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in its first StReq cycle (request at the reset PC).
  task automatic boot();
    reset = 1'b0;
    stall_id = 1'b0;
    redir_valid = 1'b0;
    force_ack = 1'b0;
    lat = 1;
    #3;
    @(negedge clk);
    reset = 1'b1;
    cyc();
  endtask

  initial begin
    stall_id = 1'b0;
    redir_valid = 1'b0;
    redir_target = '0;
    lat = 1;
    force_ack = 1'b0;
    #1 reset = 1'b0;
    #2;
    check("rst_req", 32'(im_req), 32'd0);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_instr", if_instr, 32'h0);
    check("rst_addr", im_addr, 32'h0000_3000);
    @(negedge clk);
    reset = 1'b1;
    #1 check("boot_req", 32'(im_req), 32'd0);

    // Zero-wait streaming
    cyc();
    check("a_req0", 32'(im_req), 32'd1);
    check("a_addr0", im_addr, 32'h0000_3000);
    check("a_val0", 32'(if_valid), 32'd0);
    cyc();
    check("a_pc0", if_pc, 32'h0000_3000);
    check("a_instr0", if_instr, 32'hA5A5_3000);
    check("a_addr1", im_addr, 32'h0000_3004);
    check("a_val1", 32'(if_valid), 32'd1);
    cyc();
    check("a_pc1", if_pc, 32'h0000_3004);
    cyc();
    check("a_pc2", if_pc, 32'h0000_3008);
    check("a_addr3", im_addr, 32'h0000_300C);

    // Three-cycle memory latency at 3004
    boot();
    cyc();
    lat = 3;
    #1;
    check("b_f0_addr", im_addr, 32'h0000_3004);
    check("b_f0_req", 32'(im_req), 32'd1);
    check("b_f0_val", 32'(if_valid), 32'd1);
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("b_wait_addr", im_addr, 32'h0000_3004);
      check("b_wait_req", 32'(im_req), 32'd1);
      check("b_wait_val", 32'(if_valid), 32'd0);
    end
    cyc();
    check("b_pc", if_pc, 32'h0000_3004);
    check("b_val", 32'(if_valid), 32'd1);

    // Four-cycle stall holding 3008
    lat = 1;
    #1;
    cyc();
    stall_id = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("c_req", 32'(im_req), 32'd0);
      check("c_pc", if_pc, 32'h0000_3008);
      check("c_instr", if_instr, 32'hA5A5_3008);
      check("c_val", 32'(if_valid), 32'd1);
      cyc();
    end
    stall_id = 1'b0;
    #1;
    check("c_rel_addr", im_addr, 32'h0000_300C);
    check("c_rel_req", 32'(im_req), 32'd1);

    // Redirect from StFull: 300C is the delay slot, 3010 must never be requested
    n0 = n3010;
    cyc();
    check("d_pc", if_pc, 32'h0000_300C);
    redir_valid = 1'b1;
    redir_target = 32'h0000_3040;
    #1;
    check("d_bub_req", 32'(im_req), 32'd0);
    cyc();
    redir_valid = 1'b0;
    #1;
    check("d_val", 32'(if_valid), 32'd0);
    check("d_addr", im_addr, 32'h0000_3040);
    check("d_req", 32'(im_req), 32'd1);
    cyc();
    check("d_pc2", if_pc, 32'h0000_3040);
    check("d_instr", if_instr, 32'hA5A5_3040);
    check("d_no3010", 32'(n3010), 32'(n0));

    // Redirect to the top word: PC increment wraps to zero
    redir_valid = 1'b1;
    redir_target = 32'hFFFF_FFFC;
    #1;
    cyc();
    redir_valid = 1'b0;
    #1;
    check("g_addr", im_addr, 32'hFFFF_FFFC);
    cyc();
    check("g_pc", if_pc, 32'hFFFF_FFFC);
    check("g_wrap", im_addr, 32'h0000_0000);

    // Redirect in StReq, delay slot 300C still pending
    boot();
    cyc();
    cyc();
    cyc();
    check("e1_pc0", if_pc, 32'h0000_3008);
    lat = 3;
    #1;
    cyc();
    redir_valid = 1'b1;
    redir_target = 32'h0000_3100;
    #1;
    check("e1_val", 32'(if_valid), 32'd0);
    check("e1_addr", im_addr, 32'h0000_300C);
    cyc();
    redir_valid = 1'b0;
    #1;
    check("e1_addr2", im_addr, 32'h0000_300C);
    check("e1_req", 32'(im_req), 32'd1);
    cyc();
    check("e1_pc", if_pc, 32'h0000_300C);
    check("e1_instr", if_instr, 32'hA5A5_300C);
    check("e1_tgt", im_addr, 32'h0000_3100);

    // Same, but the delay slot acks in the redirect cycle
    boot();
    cyc();
    cyc();
    cyc();
    lat = 2;
    #1;
    cyc();
    redir_valid = 1'b1;
    redir_target = 32'h0000_3100;
    #1;
    check("e2_ack", 32'(im_ack), 32'd1);
    cyc();
    redir_valid = 1'b0;
    #1;
    check("e2_pc", if_pc, 32'h0000_300C);
    check("e2_tgt", im_addr, 32'h0000_3100);
    check("e2_val", 32'(if_valid), 32'd1);

    // Async reset mid-request at 3020, then a stray ack during boot
    boot();
    for (int i = 0; i < 8; i++) cyc();
    check("f_pc", if_pc, 32'h0000_301C);
    check("f_addr", im_addr, 32'h0000_3020);
    lat = 4;
    #1;
    cyc();
    check("f_req", 32'(im_req), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("f_rst_req", 32'(im_req), 32'd0);
    check("f_rst_val", 32'(if_valid), 32'd0);
    check("f_rst_addr", im_addr, 32'h0000_3000);
    force_ack = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    lat = 1;
    cyc();
    force_ack = 1'b0;
    #1;
    check("f_late_val", 32'(if_valid), 32'd0);
    check("f_late_pc", if_pc, 32'h0);
    check("f_restart", im_addr, 32'h0000_3000);
    cyc();
    check("f_pc2", if_pc, 32'h0000_3000);
    check("f_val2", 32'(if_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
